// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 16x-oversampled UART receiver that assembles fixed-length frames with timeout and framing-error discard
module uart_frame_rx #(
  parameter int CLK_FREQ     = 103_340_000,
  parameter int BAUD         = 9600,
  parameter int DBITS        = 8,
  parameter int FRAME_BYTES  = 18,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  output logic [FRAME_BYTES*DBITS-1:0] frame_out,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic                         busy,
  output logic [7:0]                   byte_count
);
  localparam int DIV_F = CLK_FREQ / (BAUD * 16);
  localparam int DIV   = DIV_F < 1 ? 1 : DIV_F;
  localparam int TO    = TIMEOUT_BITS * 16;
  localparam int TW    = $clog2(DIV + 1);
  localparam int OW    = $clog2(TO + 1);
  localparam int BW    = $clog2(DBITS + 1);
  localparam int FW    = FRAME_BYTES * DBITS;
  localparam int SW    = FW - DBITS;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
  state_t          state;
  logic            s1, s2, prev_hi;
  logic [1:0]      sync_ok;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      os;
  logic [BW-1:0]   bit_cnt;
  logic [DBITS-1:0] char_sr;
  logic [SW-1:0]   shadow;
  logic [OW-1:0]   to_cnt;
  logic            tick, fall, start, last_char, to_hit;
  assign tick      = tick_cnt == TW'(DIV - 1);
  assign fall      = prev_hi & ~s2;
  assign start     = state == IDLE && fall;
  assign last_char = byte_count == 8'(FRAME_BYTES - 1);
  assign to_hit    = tick && to_cnt == OW'(TO - 1) && byte_count != 8'd0;
  assign busy      = state != IDLE || byte_count != 8'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      sync_ok <= 2'b00;
      prev_hi <= 1'b0;
    end else begin
      s1      <= rx;
      s2      <= s1;
      sync_ok <= {sync_ok[0], 1'b1};
      prev_hi <= sync_ok[1] & s2;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else tick_cnt <= (tick || start) ? '0 : tick_cnt + TW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      os          <= '0;
      bit_cnt     <= '0;
      char_sr     <= '0;
      shadow      <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      byte_count  <= '0;
      to_cnt      <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      to_cnt      <= (state == IDLE && byte_count != 8'd0 && !start) ? to_cnt + OW'(tick) : '0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= START;
            os    <= '0;
          end else if (to_hit) begin
            frame_err  <= 1'b1;
            byte_count <= '0;
            shadow     <= '0;
          end
        end
        START: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd7) begin
              state   <= s2 ? IDLE : DATA;
              os      <= '0;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd15) begin
              char_sr <= {s2, char_sr[DBITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DBITS - 1)) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd15) begin
              if (!s2) begin
                frame_err  <= 1'b1;
                byte_count <= '0;
                shadow     <= '0;
                state      <= RECOVER;
              end else if (last_char) begin
                frame_out   <= {shadow, char_sr};
                frame_valid <= 1'b1;
                byte_count  <= '0;
                shadow      <= '0;
                state       <= IDLE;
              end else begin
                shadow     <= SW'({shadow, char_sr});
                byte_count <= byte_count + 8'd1;
                state      <= IDLE;
              end
            end
          end
        end
        RECOVER: state <= s2 ? IDLE : RECOVER;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: table-driven and randomized checks of uart_frame_rx against a queue-based frame model
module tb_uart_frame_rx;
  localparam int FB = 18;
  localparam int DB = 8;
  localparam int FW = FB * DB;
  localparam logic [FW-1:0] MSG_FRAME = 144'h7B68695F69276D5F796F75725F61726D797D;
  typedef struct {
    logic [7:0] d;
    bit         ok;
    int         gap;
    int         cnt_char;
    int         cnt_gap;
    int         nerr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic [FW-1:0] frame_out;
  logic frame_valid, frame_err, busy;
  logic [7:0] byte_count;
  int vectors = 0;
  int miscompares = 0;
  int nv = 0;
  int ne = 0;
  int cyc = 0;
  int v_cyc = 0;
  int v_cyc_prev = 0;
  logic [7:0] q[$];
  logic [FW-1:0] exp_fo = '0;
  int exp_nv = 0;
  int exp_ne = 0;
  logic [7:0] msg [FB] = '{8'h7B, 8'h68, 8'h69, 8'h5F, 8'h69, 8'h27, 8'h6D, 8'h5F, 8'h79,
                           8'h6F, 8'h75, 8'h72, 8'h5F, 8'h61, 8'h72, 8'h6D, 8'h79, 8'h7D};
  vec_t tbl [9];
  uart_frame_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DBITS(DB), .FRAME_BYTES(FB), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_err(frame_err), .busy(busy), .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_err)) begin
      check("valid_err_exclusive", FW'(frame_valid & frame_err), '0);
      if (frame_valid) begin
        nv++;
        v_cyc_prev = v_cyc;
        v_cyc = cyc;
      end
      if (frame_err) ne++;
    end
  end
  function automatic void model_char(input logic [7:0] d, input bit ok);
    if (!ok) begin
      exp_ne++;
      q.delete();
    end else begin
      q.push_back(d);
      if (q.size() == FB) begin
        exp_fo = '0;
        foreach (q[i]) exp_fo = (exp_fo << 8) | FW'(q[i]);
        exp_nv++;
        q.delete();
      end
    end
  endfunction
  function automatic void model_gap(input int gap);
    if (gap >= 22 && q.size() > 0) begin
      exp_ne++;
      q.delete();
    end
  endfunction
  function automatic void model_reset();
    q.delete();
    exp_fo = '0;
  endfunction
  task automatic send_char(input logic [7:0] d, input bit stop_ok);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_ok;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic xfer(input logic [7:0] d, input bit ok, input int gap);
    int c0, nv0;
    c0 = cyc;
    nv0 = nv;
    send_char(d, ok);
    model_char(d, ok);
    check("count_after_char", FW'(byte_count), FW'(q.size()));
    check("valid_pulses", FW'(nv), FW'(exp_nv));
    check("err_pulses", FW'(ne), FW'(exp_ne));
    if (nv != nv0) check("valid_in_stop_bit", FW'((cyc >= 0) && (v_cyc - c0 >= 145) && (v_cyc - c0 <= 160)), FW'(1));
    repeat (gap * 16) @(negedge clk);
    model_gap(gap);
    check("count_after_gap", FW'(byte_count), FW'(q.size()));
    check("err_after_gap", FW'(ne), FW'(exp_ne));
    check("frame_out", frame_out, exp_fo);
    if (gap > 0) check("busy_idle", FW'(busy), FW'(q.size() > 0));
  endtask
  initial begin
    int ne0, nv0, gap;
    bit ok;
    logic [7:0] d;
    tbl = '{
      '{8'h11, 1'b1, 0, 1, 1, 0}, '{8'h22, 1'b1, 0, 2, 2, 0}, '{8'h33, 1'b1, 0, 3, 3, 0},
      '{8'h44, 1'b0, 2, 0, 0, 1}, '{8'h55, 1'b1, 0, 1, 1, 1}, '{8'h66, 1'b1, 0, 2, 2, 1},
      '{8'h77, 1'b1, 0, 3, 3, 1}, '{8'h88, 1'b1, 0, 4, 4, 1}, '{8'h99, 1'b1, 22, 5, 0, 2}};
    repeat (4) @(negedge clk);
    check("rst_frame_out", frame_out, '0);
    check("rst_valid", FW'(frame_valid), '0);
    check("rst_err", FW'(frame_err), '0);
    check("rst_busy", FW'(busy), '0);
    check("rst_count", FW'(byte_count), '0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", FW'(nv), '0);
    check("glitch_err", FW'(ne), '0);
    check("glitch_count", FW'(byte_count), '0);
    check("glitch_busy", FW'(busy), '0);
    for (int i = 0; i < FB; i++) xfer(msg[i], 1'b1, 0);
    repeat (32) @(negedge clk);
    check("msg_frame", frame_out, MSG_FRAME);
    check("msg_one_valid", FW'(nv), FW'(1));
    check("msg_count", FW'(byte_count), '0);
    ne0 = ne;
    foreach (tbl[i]) begin
      send_char(tbl[i].d, tbl[i].ok);
      model_char(tbl[i].d, tbl[i].ok);
      check("tbl_count_char", FW'(byte_count), FW'(tbl[i].cnt_char));
      repeat (tbl[i].gap * 16) @(negedge clk);
      model_gap(tbl[i].gap);
      check("tbl_count_gap", FW'(byte_count), FW'(tbl[i].cnt_gap));
      check("tbl_errs", FW'(ne - ne0), FW'(tbl[i].nerr));
      check("tbl_frame_hold", frame_out, MSG_FRAME);
      if (tbl[i].gap > 0) check("tbl_busy", FW'(busy), FW'(tbl[i].cnt_gap != 0));
    end
    for (int i = 0; i < FB; i++) xfer(8'($urandom), 1'b1, 0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 9; i++) xfer(8'($urandom), 1'b1, 0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    ne0 = ne;
    repeat (40) @(negedge clk);
    check("midrst_count", FW'(byte_count), '0);
    check("midrst_busy", FW'(busy), '0);
    check("midrst_frame_out", frame_out, '0);
    nv0 = nv;
    for (int i = 0; i < FB; i++) xfer(8'($urandom), 1'b1, 0);
    check("midrst_no_err", FW'(ne - ne0), '0);
    check("midrst_one_valid", FW'(nv - nv0), FW'(1));
    reset = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    ne0 = ne;
    repeat (40) @(negedge clk);
    check("lowrst_busy", FW'(busy), '0);
    check("lowrst_count", FW'(byte_count), '0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("lowrst_busy_hi", FW'(busy), '0);
    check("lowrst_no_err", FW'(ne - ne0), '0);
    nv0 = nv;
    for (int i = 0; i < 2 * FB; i++) xfer(8'($urandom), 1'b1, 0);
    check("b2b_two_valid", FW'(nv - nv0), FW'(2));
    check("b2b_spacing", FW'(v_cyc - v_cyc_prev), FW'(FB * 10 * 16));
    for (int i = 0; i < 120; i++) begin
      d = 8'($urandom);
      ok = $urandom_range(0, 7) != 0;
      gap = !ok ? int'($urandom_range(1, 2)) :
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 24)) : int'($urandom_range(0, 2));
      xfer(d, ok, gap);
    end
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 103_340_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: line bit rate.
REQ-003 SHALL have parameter DBITS, default 8: data bits per character.
REQ-004 SHALL have parameter FRAME_BYTES, default 18: characters per frame.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 20: maximum idle gap between characters of one frame, in bit periods.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-009 SHALL have port frame_out, output, FRAME_BYTES*DBITS bits: last complete frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when frame_out updates.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial frame is discarded.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is partially received or a character is in progress.
REQ-013 SHALL have port byte_count, output, 8 bits: characters accepted in the current partial frame.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer, flops preset to 1, before any use.
REQ-015 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, integer floor, with a minimum of 1; the tick counter free-runs except that it restarts on start-edge detection.
REQ-016 SHALL implement states IDLE, START, DATA, STOP and RECOVER.
REQ-017 IDLE: on a synchronized 1->0 transition, go to START and clear the tick count.
REQ-018 START: on the 8th tick, sample rx. If low, go to DATA. If high, treat it as a glitch and return to IDLE with no error and byte_count unchanged.
REQ-019 DATA: sample on every 16th tick after the start mid-point, LSB first; after DBITS samples, go to STOP.
REQ-020 STOP: sample on the 16th tick. If high, accept the character and return to IDLE. If low, report a framing error and go to RECOVER.
REQ-021 RECOVER: wait for synchronized rx high, then go to IDLE.
REQ-022 Character store: accepted characters SHALL fill a shadow buffer with the first character in the most-significant byte, frame_out[FRAME_BYTES*DBITS-1 -: DBITS], and later characters in descending byte positions.
REQ-023 On acceptance of character number FRAME_BYTES, the clock edge that accepts it SHALL copy the shadow buffer including that character into frame_out, pulse frame_valid for exactly 1 cycle, and clear byte_count to 0.
REQ-024 The latency from the stop-bit sample to frame_valid SHALL be 1 clock.
REQ-025 frame_out SHALL hold its value until the next complete frame; partial frames never alter it.
REQ-026 A framing error SHALL pulse frame_err for 1 cycle, clear byte_count and discard the shadow buffer contents.
REQ-027 Timeout: while in IDLE with byte_count > 0, if TIMEOUT_BITS*16 ticks elapse with no start edge, SHALL pulse frame_err, clear byte_count and stay in IDLE.
REQ-028 A start edge in the same cycle as the timeout expiry SHALL take priority: no error, and the character is received normally.
REQ-029 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-030 busy SHALL be 1 when the state is not IDLE or byte_count > 0, and 0 otherwise.
REQ-031 A character that begins after a frame completes SHALL start a new frame at byte 0; there is no frame delimiter.

Reset
REQ-032 While reset is high at a clock edge, the block SHALL set: state IDLE, frame_out 0, frame_valid 0, frame_err 0, busy 0, byte_count 0, shadow buffer 0, tick and timeout counters 0, synchronizer flops 1.
REQ-033 Reset asserted mid-character or mid-frame SHALL discard all partial data without a frame_err pulse.
REQ-034 After reset deasserts, the block SHALL require a fresh high-to-low rx edge before starting reception; rx held low through reset SHALL NOT start a character.

Verification
REQ-035 With CLK_FREQ=1_600_000, BAUD=100_000 and FRAME_BYTES=18, sending the 18 bytes 7B 68 69 5F 69 27 6D 5F 79 6F 75 72 5F 61 72 6D 79 7D SHALL produce exactly one frame_valid pulse, frame_out = 0x7B68695F69276D5F796F75725F61726D797D, and byte_count returning to 0.
REQ-036 Under the same parameters, a 5-clock low pulse on idle rx SHALL produce no frame_valid, no frame_err and byte_count = 0.
REQ-037 Sending 3 good bytes followed by a byte whose stop bit is low SHALL produce a frame_err pulse and byte_count = 0, leave frame_out unchanged, and a following full 18-byte frame SHALL be received correctly.
REQ-038 Sending 5 bytes and then idling for 21 bit periods SHALL produce a frame_err pulse and byte_count 5->0, with busy falling to 0.
REQ-039 Asserting reset for 1 cycle during byte 10 of a frame, then sending a full frame, SHALL produce no frame_err, frame_out = the new frame, and exactly one frame_valid pulse.
REQ-040 Sending two back-to-back frames with zero idle gap SHALL produce two frame_valid pulses 18 character times apart, each with the correct frame_out.
